// File: rtl/note_track.sv
// note_track: four-lane falling-note tracker with pattern-driven spawning; define NOTE_TRACK_MISS_COUNT_EN to add miss_count
module note_track #(
    parameter int SLOTS      = 4,
    parameter int NOTE_SIZE  = 50,
    parameter int LANE0_X    = 170,
    parameter int LANE_PITCH = 100,
    parameter int SCREEN_H   = 480,
    parameter int NOTE_SPEED = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       spawn_tick,
    input  logic       pat_valid,
    input  logic [3:0] pat,
    output logic       pat_ready,
    input  logic [9:0] px,
    input  logic [8:0] py,
    output logic [3:0] in_note,
    output logic       overflow,
`ifdef NOTE_TRACK_MISS_COUNT_EN
    output logic [7:0] miss_count,
`endif
    output logic [4:0] live_count
);
    typedef enum logic [1:0] {IDLE, WAIT_PAT, ALLOC} state_t;
    state_t state, state_nx;
    logic [3:0] pat_q;
    logic [SLOTS-1:0] valid [4];
    logic [SLOTS-1:0] valid_nx [4];
    logic [9:0] ytop [4][SLOTS];
    logic [9:0] ytop_nx [4][SLOTS];
    logic drop;
    logic found;
    logic [4:0] retired;
    logic [4:0] cnt;
    logic [3:0] hit;
    // spawn handshake sequencing; spawn_tick outside IDLE falls through unqueued
    always_comb begin
        state_nx = state;
        pat_ready = (state == WAIT_PAT);
        if (state == IDLE && spawn_tick)
            state_nx = WAIT_PAT;
        else if (state == WAIT_PAT && pat_valid)
            state_nx = ALLOC;
        else if (state == ALLOC)
            state_nx = IDLE;
    end
    // slot update: advance/retire on frame_tick, then allocate from slots free before this cycle
    always_comb begin
        drop = 1'b0;
        found = 1'b0;
        retired = '0;
        valid_nx = valid;
        ytop_nx = ytop;
        for (int l = 0; l < 4; l++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (frame_tick && valid[l][s]) begin
                    if ({1'b0, ytop[l][s]} + 11'(NOTE_SPEED) < 11'(SCREEN_H)) begin
                        ytop_nx[l][s] = ytop[l][s] + 10'(NOTE_SPEED);
                    end else begin
                        valid_nx[l][s] = 1'b0;
                        ytop_nx[l][s] = '0;
                        retired = retired + 5'd1;
                    end
                end
            end
            if (state == ALLOC && pat_q[l]) begin
                found = 1'b0;
                for (int s = 0; s < SLOTS; s++) begin
                    if (!found && !valid[l][s]) begin
                        found = 1'b1;
                        valid_nx[l][s] = 1'b1;
                        ytop_nx[l][s] = '0;
                    end
                end
                if (!found)
                    drop = 1'b1;
            end
        end
    end
    // live popcount and per-lane pixel hit test against the current slot contents
    always_comb begin
        cnt = '0;
        hit = '0;
        for (int l = 0; l < 4; l++) begin
            for (int s = 0; s < SLOTS; s++) begin
                cnt = cnt + {4'd0, valid[l][s]};
                if (valid[l][s] && int'(px) >= LANE0_X + l * LANE_PITCH
                    && int'(px) < LANE0_X + l * LANE_PITCH + NOTE_SIZE
                    && int'(py) >= int'(ytop[l][s]) && int'(py) < int'(ytop[l][s]) + NOTE_SIZE)
                    hit[l] = 1'b1;
            end
        end
    end
    // state, slot and registered output update
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pat_q <= '0;
            valid <= '{default: '0};
            ytop <= '{default: '0};
            overflow <= 1'b0;
            live_count <= '0;
            in_note <= '0;
        end else begin
            state <= state_nx;
            if (state == WAIT_PAT && pat_valid)
                pat_q <= pat;
            valid <= valid_nx;
            ytop <= ytop_nx;
            overflow <= overflow | drop;
            live_count <= cnt;
            in_note <= hit;
        end
    end
`ifdef NOTE_TRACK_MISS_COUNT_EN
    logic [8:0] miss_sum;
    // saturating sum of retired slots
    always_comb miss_sum = {1'b0, miss_count} + {4'd0, retired};
    // miss counter register
    always_ff @(posedge clk) begin
        if (reset)
            miss_count <= '0;
        else
            miss_count <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end
`endif
endmodule
